// File: rtl/jellyvl_synctimer_pkg.sv
// Shared constants and types for the synctimer link receiver: packet commands
// and the receive-parser state encoding.
package jellyvl_synctimer_pkg;

    localparam logic [7:0] CMD_SYNC     = 8'hA5;
    localparam logic [7:0] CMD_OVERRIDE = 8'hA6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TIME,
        ST_SUM,
        ST_DROP
    } rx_state_t;

    function automatic logic is_cmd(input logic [7:0] b);
        return (b == CMD_SYNC) || (b == CMD_OVERRIDE);
    endfunction

endpackage

// File: rtl/jellyvl_synctimer_elapsed.sv
// Fractional elapsed-time accumulator: advances by NUMERATOR/DENOMINATOR time units
// per clock, saturating at all-ones. elapsed_o already includes the current cycle.
module jellyvl_synctimer_elapsed #(
    parameter int NUMERATOR     = 10,
    parameter int DENOMINATOR   = 3,
    parameter int ELAPSED_WIDTH = 24
) (
    input  logic                     reset,
    input  logic                     clk,
    input  logic                     clear_i,
    output logic [ELAPSED_WIDTH-1:0] elapsed_o
);

    localparam int FRAC_W    = $clog2(2 * DENOMINATOR) + 1;
    localparam int INT_STEP  = NUMERATOR / DENOMINATOR;
    localparam int FRAC_STEP = NUMERATOR % DENOMINATOR;

    logic [ELAPSED_WIDTH-1:0] int_q, int_d, int_base;
    logic [FRAC_W-1:0]        frac_q, frac_d, frac_base, frac_sum;
    logic                     carry;

    function automatic logic [ELAPSED_WIDTH-1:0] sat_add(
        input logic [ELAPSED_WIDTH-1:0] a,
        input logic [ELAPSED_WIDTH:0]   b
    );
        logic [ELAPSED_WIDTH+1:0] s;
        s = (ELAPSED_WIDTH+2)'(a) + (ELAPSED_WIDTH+2)'(b);
        if (s[ELAPSED_WIDTH+1:ELAPSED_WIDTH] != 2'b00) begin
            return '1;
        end
        return s[ELAPSED_WIDTH-1:0];
    endfunction

    // Clearing restarts from zero, so the first-byte cycle itself counts as one step.
    always_comb begin
        int_base  = clear_i ? '0 : int_q;
        frac_base = clear_i ? '0 : frac_q;
        frac_sum  = frac_base + FRAC_W'(FRAC_STEP);
        carry     = (frac_sum >= FRAC_W'(DENOMINATOR));
        frac_d    = carry ? (frac_sum - FRAC_W'(DENOMINATOR)) : frac_sum;
        int_d     = sat_add(int_base, (ELAPSED_WIDTH+1)'(INT_STEP) + (ELAPSED_WIDTH+1)'(carry));
    end

    assign elapsed_o = int_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            int_q  <= '0;
            frac_q <= '0;
        end else begin
            int_q  <= int_d;
            frac_q <= frac_d;
        end
    end

endmodule

// File: rtl/jellyvl_synctimer_rx_parser.sv
// Time-sync packet parser: cmd, LSB-first timestamp, zero-sum checksum. Emits the
// received time compensated by link offset and in-packet elapsed time.
module jellyvl_synctimer_rx_parser
    import jellyvl_synctimer_pkg::*;
#(
    parameter int TIMER_WIDTH    = 64,
    parameter int NUMERATOR      = 10,
    parameter int DENOMINATOR    = 3,
    parameter int ELAPSED_WIDTH  = 24,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int OFFSET_WIDTH   = 32
) (
    input  logic                           reset,
    input  logic                           clk,
    input  logic signed [OFFSET_WIDTH-1:0] param_offset,
    input  logic [7:0]                     s_data,
    input  logic                           s_first,
    input  logic                           s_last,
    input  logic                           s_valid,
    output logic [TIMER_WIDTH-1:0]         correct_time,
    output logic                           correct_override,
    output logic                           correct_valid,
    output logic                           err_checksum,
    output logic                           err_format
);

    localparam int TIME_BYTES = TIMER_WIDTH / 8;
    localparam int IDX_W      = $clog2(TIME_BYTES + 1);
    localparam int GAP_W      = $clog2(TIMEOUT_CYCLES + 1);

    rx_state_t               state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [7:0]              sum_q, sum_d, sum_total;
    logic [TIMER_WIDTH-1:0]  time_q, time_d;
    logic                    ovr_q, ovr_d;
    logic [GAP_W-1:0]        gap_q, gap_d;
    logic [TIMER_WIDTH-1:0]  ctime_q, ctime_d;
    logic                    covr_q, covr_d;
    logic                    cvalid_q, cvalid_d;
    logic                    echk_q, echk_d;
    logic                    efmt_q, efmt_d;
    logic                    elapsed_clear;
    logic [ELAPSED_WIDTH-1:0] elapsed;
    logic [TIMER_WIDTH-1:0]  offset_ext;

    // Signed size cast sign-extends the link offset to the timer width.
    assign offset_ext = TIMER_WIDTH'(param_offset);

    jellyvl_synctimer_elapsed #(
        .NUMERATOR    (NUMERATOR),
        .DENOMINATOR  (DENOMINATOR),
        .ELAPSED_WIDTH(ELAPSED_WIDTH)
    ) u_elapsed (
        .reset    (reset),
        .clk      (clk),
        .clear_i  (elapsed_clear),
        .elapsed_o(elapsed)
    );

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        sum_d         = sum_q;
        time_d        = time_q;
        ovr_d         = ovr_q;
        gap_d         = gap_q;
        ctime_d       = ctime_q;
        covr_d        = covr_q;
        cvalid_d      = 1'b0;
        echk_d        = 1'b0;
        efmt_d        = 1'b0;
        elapsed_clear = 1'b0;
        sum_total     = sum_q + s_data;

        if (s_valid && s_first) begin
            // A first byte always restarts parsing, aborting any packet in flight.
            gap_d         = '0;
            idx_d         = '0;
            sum_d         = s_data;
            ovr_d         = (s_data == CMD_OVERRIDE);
            elapsed_clear = 1'b1;
            efmt_d        = (state_q != ST_IDLE) || !is_cmd(s_data) || s_last;
            if (is_cmd(s_data) && !s_last) begin
                state_d = ST_TIME;
            end else if (s_last) begin
                state_d = ST_IDLE;
            end else begin
                state_d = ST_DROP;
            end
        end else if (s_valid) begin
            gap_d = '0;
            case (state_q)
                ST_TIME: begin
                    if (s_last) begin
                        efmt_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        time_d = {s_data, time_q[TIMER_WIDTH-1:8]};
                        sum_d  = sum_total;
                        idx_d  = idx_q + 1'b1;
                        if (idx_q == IDX_W'(TIME_BYTES - 1)) begin
                            state_d = ST_SUM;
                        end
                    end
                end
                ST_SUM: begin
                    if (s_last) begin
                        state_d = ST_IDLE;
                        if (sum_total == 8'h00) begin
                            cvalid_d = 1'b1;
                            covr_d   = ovr_q;
                            ctime_d  = time_q + offset_ext + TIMER_WIDTH'(elapsed);
                        end else begin
                            echk_d = 1'b1;
                        end
                    end else begin
                        efmt_d  = 1'b1;
                        state_d = ST_DROP;
                    end
                end
                ST_DROP: begin
                    if (s_last) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                end
            endcase
        end else if ((state_q == ST_TIME) || (state_q == ST_SUM)) begin
            if (gap_q == GAP_W'(TIMEOUT_CYCLES - 1)) begin
                efmt_d  = 1'b1;
                state_d = ST_IDLE;
            end else begin
                gap_d = gap_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            sum_q    <= '0;
            time_q   <= '0;
            ovr_q    <= 1'b0;
            gap_q    <= '0;
            ctime_q  <= '0;
            covr_q   <= 1'b0;
            cvalid_q <= 1'b0;
            echk_q   <= 1'b0;
            efmt_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            sum_q    <= sum_d;
            time_q   <= time_d;
            ovr_q    <= ovr_d;
            gap_q    <= gap_d;
            ctime_q  <= ctime_d;
            covr_q   <= covr_d;
            cvalid_q <= cvalid_d;
            echk_q   <= echk_d;
            efmt_q   <= efmt_d;
        end
    end

    assign correct_time     = ctime_q;
    assign correct_override = covr_q;
    assign correct_valid    = cvalid_q;
    assign err_checksum     = echk_q;
    assign err_format       = efmt_q;

endmodule

// File: tb/tb_jellyvl_synctimer_rx_parser.sv
// Scoreboard bench for the synctimer receive parser.
module tb_jellyvl_synctimer_rx_parser;

    localparam int TIMEOUT = 1000;
    localparam logic [2:0] K_VALID = 3'b100;
    localparam logic [2:0] K_CHK   = 3'b010;
    localparam logic [2:0] K_FMT   = 3'b001;

    logic               clk = 1'b0;
    logic               reset;
    logic signed [31:0] offset;
    logic [7:0]         s_data;
    logic               s_first, s_last, s_valid;
    logic [63:0]        correct_time;
    logic               correct_override, correct_valid, err_checksum, err_format;

    typedef struct {
        int          cyc;
        logic [2:0]  kind;
        logic [63:0] t;
        logic        ovr;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    logic [63:0] model_time = '0;

    jellyvl_synctimer_rx_parser #(
        .TIMER_WIDTH   (64),
        .NUMERATOR     (10),
        .DENOMINATOR   (3),
        .ELAPSED_WIDTH (24),
        .TIMEOUT_CYCLES(TIMEOUT),
        .OFFSET_WIDTH  (32)
    ) dut (
        .reset           (reset),
        .clk             (clk),
        .param_offset    (offset),
        .s_data          (s_data),
        .s_first         (s_first),
        .s_last          (s_last),
        .s_valid         (s_valid),
        .correct_time    (correct_time),
        .correct_override(correct_override),
        .correct_valid   (correct_valid),
        .err_checksum    (err_checksum),
        .err_format      (err_format)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(input int c, input logic [2:0] k, input logic [63:0] t, input logic o);
        exp_t e;
        e.cyc = c; e.kind = k; e.t = t; e.ovr = o;
        sb.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic f, input logic l);
        @(posedge clk); #1;
        s_valid = 1'b1; s_data = d; s_first = f; s_last = l;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            s_valid = 1'b0; s_first = 1'b0; s_last = 1'b0;
        end
    endtask

    task automatic send_packet(input logic [7:0] cmd, input logic [63:0] t, input int gap,
                               input bit corrupt, input bit abort, input bit nolast);
        logic [7:0]  b, s;
        logic [63:0] el, et;
        int          first_cyc;
        s = cmd;
        send_byte(cmd, 1'b1, 1'b0);
        first_cyc = cyc;
        if (abort) push(cyc + 1, K_FMT, model_time, 1'b0);
        for (int i = 0; i < 8; i++) begin
            idle(gap);
            b = t[i*8 +: 8];
            s = s + b;
            send_byte(b, 1'b0, 1'b0);
        end
        idle(gap);
        s = 8'h00 - s;
        if (corrupt) s = s + 8'h01;
        send_byte(s, 1'b0, !nolast);
        if (nolast) begin
            push(cyc + 1, K_FMT, model_time, 1'b0);
        end else if (corrupt) begin
            push(cyc + 1, K_CHK, model_time, 1'b0);
        end else begin
            el = 64'((cyc - first_cyc + 1) * 10 / 3);
            et = t + {{32{offset[31]}}, offset} + el;
            model_time = et;
            push(cyc + 1, K_VALID, et, cmd == 8'hA6);
        end
        idle(1);
    endtask

    // Output monitor: every pulse must match the head of the scoreboard in cycle and kind.
    logic [2:0] pulse;
    exp_t       me;
    always @(negedge clk) begin
        if (!reset) begin
            pulse = {correct_valid, err_checksum, err_format};
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                me = sb.pop_front();
                check_val("pulse_kind", 64'(pulse), 64'(me.kind));
                check_val("correct_time", correct_time, me.t);
                if (me.kind == K_VALID) check_val("override", 64'(correct_override), 64'(me.ovr));
            end else if (pulse != 3'b000) begin
                check_val("stray_pulse", 64'(pulse), 64'd0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; offset = 32'sd5;
        s_data = 8'h00; s_first = 1'b0; s_last = 1'b0; s_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_time", correct_time, 64'd0);
        check_val("rst_valid", 64'(correct_valid), 64'd0);
        check_val("rst_ovr", 64'(correct_override), 64'd0);
        check_val("rst_chk", 64'(err_checksum), 64'd0);
        check_val("rst_fmt", 64'(err_format), 64'd0);
        reset = 1'b0;
        idle(3);

        // back-to-back SYNC, then OVERRIDE with 2-cycle gaps
        send_packet(8'hA5, 64'h1000, 0, 1'b0, 1'b0, 1'b0);
        send_packet(8'hA6, 64'h1000, 2, 1'b0, 1'b0, 1'b0);
        // corrupted checksum: time must hold
        send_packet(8'hA5, 64'h2222_3333_4444_5555, 0, 1'b1, 1'b0, 1'b0);
        idle(2);

        // bad command then 9 bytes ending with last
        send_byte(8'h00, 1'b1, 1'b0);
        push(cyc + 1, K_FMT, model_time, 1'b0);
        for (int i = 0; i < 9; i++) send_byte(8'(i + 3), 1'b0, i == 8);
        idle(1);
        send_packet(8'hA5, 64'h0123_4567_89AB_CDEF, 1, 1'b0, 1'b0, 1'b0);

        // new first after 4 time bytes aborts and restarts
        send_byte(8'hA5, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) send_byte(8'h77, 1'b0, 1'b0);
        send_packet(8'hA6, 64'hDEAD_BEEF_0000_0042, 0, 1'b0, 1'b1, 1'b0);

        // early last inside timestamp
        send_byte(8'hA6, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) send_byte(8'h10, 1'b0, 1'b0);
        send_byte(8'h10, 1'b0, 1'b1);
        push(cyc + 1, K_FMT, model_time, 1'b0);
        idle(1);

        // sum byte without last -> drop until last
        send_packet(8'hA5, 64'h55, 0, 1'b0, 1'b0, 1'b1);
        send_byte(8'h11, 1'b0, 1'b0);
        send_byte(8'h12, 1'b0, 1'b1);
        idle(1);
        // stray bytes in idle are ignored
        send_byte(8'hA5, 1'b0, 1'b0);
        send_byte(8'h5B, 1'b0, 1'b1);
        idle(1);
        send_packet(8'hA5, 64'h0000_0000_1234_5678, 0, 1'b0, 1'b0, 1'b0);

        // timeout mid-packet
        send_byte(8'hA5, 1'b1, 1'b0);
        send_byte(8'h01, 1'b0, 1'b0);
        send_byte(8'h02, 1'b0, 1'b0);
        push(cyc + TIMEOUT + 1, K_FMT, model_time, 1'b0);
        idle(TIMEOUT + 5);
        // gaps of TIMEOUT-1 stay within the limit
        send_packet(8'hA6, 64'h0000_0000_0000_9000, TIMEOUT - 1, 1'b0, 1'b0, 1'b0);

        // wrap-around with negative offset
        offset = -32'sd20;
        send_packet(8'hA5, 64'hFFFF_FFFF_FFFF_FFF0, 2, 1'b0, 1'b0, 1'b0);
        send_packet(8'hA5, 64'hFFFF_FFFF_FFFF_FFF0, 0, 1'b0, 1'b0, 1'b0);
        idle(3);

        // async reset mid-packet
        send_byte(8'hA6, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) send_byte(8'h20, 1'b0, 1'b0);
        @(posedge clk); #3;
        reset = 1'b1; s_valid = 1'b0; s_first = 1'b0; s_last = 1'b0;
        #1;
        check_val("midrst_time", correct_time, 64'd0);
        check_val("midrst_valid", 64'(correct_valid), 64'd0);
        check_val("midrst_fmt", 64'(err_format), 64'd0);
        model_time = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) send_byte(8'h20, 1'b0, i == 5);
        idle(5);
        offset = 32'sd5;
        send_packet(8'hA5, 64'h1000, 0, 1'b0, 1'b0, 1'b0);

        idle(20);
        check_val("sb_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
